// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch/decode side bundle of the dual-ported instruction queue.
//   master: fetch + decode side (drives issue, in1/in2, launch flags, stop, flush)
//   slave : the queue (drives out1/out2, sendout flags, instbuf_full)
interface inst_queue_if;
    logic        stop;
    logic        flush;
    logic [1:0]  issue;
    logic [31:0] in1_inst, in1_pc, in1_npc;
    logic [31:0] in2_inst, in2_pc, in2_npc;
    logic [31:0] out1_inst, out1_pc, out1_npc;
    logic [31:0] out2_inst, out2_pc, out2_npc;
    logic        sendout_flag1, sendout_flag2;
    logic        launch_flag1, launch_flag2;
    logic        instbuf_full;
    modport master (
        output stop, flush, issue,
        output in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc,
        output launch_flag1, launch_flag2,
        input  out1_inst, out1_pc, out1_npc, out2_inst, out2_pc, out2_npc,
        input  sendout_flag1, sendout_flag2, instbuf_full
    );
    modport slave (
        input  stop, flush, issue,
        input  in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc,
        input  launch_flag1, launch_flag2,
        output out1_inst, out1_pc, out1_npc, out2_inst, out2_pc, out2_npc,
        output sendout_flag1, sendout_flag2, instbuf_full
    );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: dual-push / dual-pop instruction FIFO between fetch and dual decode.
//   clk, reset : clock, asynchronous active-high reset
//   q (slave)  : fetch slots in1/in2 + issue, decode view out1/out2 + sendout flags,
//                launch flags, stop, flush, instbuf_full
//   Optional INST_QUEUE_BYPASS_EN: fetch slots fall through to empty output
//   positions in the same cycle while fewer than two entries are queued.
module inst_queue #(
    parameter int DEPTH = 8
) (
    input logic   clk,
    input logic   reset,
    inst_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, nf, lc, pop_q, byp, n_wr;
    logic [95:0]   f0, f1, q0, q1, v0, v1, w0;
    logic          byp_ok, s1, s2, full, upd;

    // f0/f1 are the valid fetch slots compacted in program order
    assign f0 = q.issue[0] ? {q.in1_inst, q.in1_pc, q.in1_npc} : {q.in2_inst, q.in2_pc, q.in2_npc};
    assign f1 = {q.in2_inst, q.in2_pc, q.in2_npc};
    assign q0 = mem[head];
    assign q1 = mem[head + AW'(1)];
    assign nf = CW'(q.issue[0]) + CW'(q.issue[1]);
    assign full = count > CW'(DEPTH - 2);
    assign upd = !q.flush && !q.stop;
`ifdef INST_QUEUE_BYPASS_EN
    assign byp_ok = !reset && upd && count < CW'(2);
`else
    assign byp_ok = 1'b0;
`endif
    assign s1 = count != '0 || (byp_ok && nf != '0);
    assign s2 = count >= CW'(2) || (byp_ok && count + nf >= CW'(2));
    assign v0 = count != '0 ? q0 : f0;
    assign v1 = count >= CW'(2) ? q1 : count == CW'(1) ? f0 : f1;
    // launch_flag2 only counts together with launch_flag1 to keep retirement in order
    assign lc = CW'(q.launch_flag1 && s1) + CW'(q.launch_flag1 && q.launch_flag2 && s2);
    // launches beyond the queued entries consume fall-through slots, which are then not stored
    assign pop_q = lc > count ? count : lc;
    assign byp = lc - pop_q;
    assign n_wr = full ? '0 : nf - byp;
    assign w0 = byp == '0 ? f0 : f1;

    assign q.sendout_flag1 = s1;
    assign q.sendout_flag2 = s2;
    assign q.instbuf_full = full;
    assign {q.out1_inst, q.out1_pc, q.out1_npc} = s1 ? v0 : '0;
    assign {q.out2_inst, q.out2_pc, q.out2_npc} = s2 ? v1 : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (!q.stop) begin
            head  <= head + pop_q[AW-1:0];
            tail  <= tail + n_wr[AW-1:0];
            count <= count + n_wr - pop_q;
        end
    end

    // entry storage needs no reset: validity is carried by count alone
    always_ff @(posedge clk) begin
        if (upd && n_wr != '0) mem[tail] <= w0;
        if (upd && n_wr == CW'(2)) mem[tail + AW'(1)] <= f1;
    end
endmodule
